multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Sequencing controller for a multicycle RV32I core with one shared instruction/data memory port.
- Steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Runs the memory request/ready handshake, drives the datapath control signals decoded from the instruction register, and flags illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles on a pending memory request before FAULT (1..1023).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  32  instruction register contents (loaded by ir_we).
- br_taken  input  1  branch condition from datapath comparator.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_we  output  1  request is a write (store).
- iord  output  1  address select: 0=PC, 1=ALU result.
- ir_we  output  1  load instruction register from memory read data.
- pc_we  output  1  update PC.
- pc_sel  output  2  PC source: 00=PC+4, 01=PC+imm (branch/jal), 10=ALU result & ~1 (jalr).
- regwrite  output  1  register file write enable.
- wb_sel  output  2  writeback source: 00=ALU, 01=mem data, 10=PC+4, 11=imm (lui).
- alusrc  output  1  ALU operand B: 0=rs2, 1=imm.
- alua_pc  output  1  ALU operand A: 0=rs1, 1=PC.
- alucontrol  output  3  ALU op (funct3 encoding).
- alu_sub  output  1  subtract / arithmetic shift select.
- instret  output  1  one-cycle pulse per retired instruction.
- fault  output  1  sticky fault flag.
- fault_cause  output  2  01=illegal opcode, 10=memory timeout, 00=none.

Behaviour:
- Reset (rst_n low, async): state=BOOT, wait counter=0, fault=0, fault_cause=00. All outputs 0 while in reset and in BOOT. BOOT moves to FETCH unconditionally next cycle.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - On mem_ready: ir_we=1, go to DECODE.
  - Otherwise hold.
- DECODE: classify instr[6:0]. Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Legal: go to EXEC.
  - Illegal: go to FAULT with cause 01.
- EXEC: ALU controls valid this cycle and held through MEM/WB.
  - R/I-ALU, lui, auipc, jal, jalr: go to WB.
  - load/store: go to MEM.
  - branch: pc_we=1, pc_sel = br_taken ? 01 : 00, instret=1, go to FETCH.
- MEM: mem_req=1, iord=1, mem_we=1 for store.
  - On mem_ready, store: pc_we=1, pc_sel=00, instret=1, go to FETCH.
  - On mem_ready, load: go to WB.
- WB: regwrite=1, pc_we=1, instret=1, go to FETCH.
  - pc_sel: 01 for jal, 10 for jalr, else 00.
  - wb_sel: 01 load, 10 jal/jalr, 11 lui, else 00.
- FAULT: sticky until rst_n. mem_req=0, all write enables 0, fault=1.
- Decode rules:
  - alucontrol = funct3 for R, I-ALU and branch; 000 otherwise.
  - alu_sub = funct7[5] for R-type funct3 000/101; = funct7[5] for I-type funct3 101 only; 1 for branch; else 0.
  - alusrc=1 for I-ALU, load, store, jalr, auipc.
  - alua_pc=1 for auipc only.
- Handshake: mem_req, iord and mem_we stay stable until mem_ready is sampled high. mem_ready is ignored when mem_req=0. mem_ready may be high in the first request cycle (zero-wait).
- Timeout counter:
  - Cleared on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle with mem_req=1 && mem_ready=0.
  - When it reaches TIMEOUT_CYCLES with no ready: go to FAULT, cause 10, mem_req drops the next cycle.
  - If mem_ready arrives on the same cycle as the limit, ready wins.
- Latency with zero-wait memory: ALU/lui/auipc/jal/jalr = 4 cycles, load = 5, store = 4, branch = 3.
  - Each wait cycle adds 1.
  - Exactly one instret pulse per retired instruction.
- rst_n asserted mid-request: mem_req drops immediately (combinational from state). A completion arriving later is ignored.

Test Plan:
- Reset release, zero-wait memory, instr=0x00500093 (addi): BOOT then FETCH → DECODE → EXEC → WB. WB shows regwrite=1, wb_sel=00, alusrc=1, alucontrol=000, pc_sel=00, and instret pulses in cycle 5 after release.
- Load 0x0000A103 with mem_ready delayed 3 cycles in MEM: MEM lasts 4 cycles with iord=1, mem_we=0. WB has wb_sel=01. Total 8 cycles; one instret.
- beq 0x00208463: br_taken=1 gives pc_sel=01, pc_we=1 in EXEC; br_taken=0 gives pc_sel=00. alu_sub=1, alucontrol=000, no regwrite.
- sub 0x40208033 vs srai 0x4010D093: both alu_sub=1. sub has alucontrol=000, alusrc=0; srai has alucontrol=101, alusrc=1.
- Illegal instr 0x0000007F: FAULT after DECODE, fault=1, fault_cause=01, mem_req stays 0 until rst_n pulse.
- TIMEOUT_CYCLES=4, mem_ready held low in FETCH: FAULT with cause 10, mem_req deasserted. Repeat with ready on the 4th wait cycle: no fault.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing controller for a multicycle RV32I core sharing one memory port.
// Steps FETCH/DECODE/EXEC/MEM/WB, runs the req/ready handshake, decodes the
// datapath controls from the instruction register and flags faults.
module multicycle_ctrl_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        regwrite,
   output logic [1:0]  wb_sel,
   output logic        alusrc,
   output logic        alua_pc,
   output logic [2:0]  alucontrol,
   output logic        alu_sub,
   output logic        instret,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   localparam int unsigned CNT_W = 10;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic       legal;
   logic       at_limit;
   logic       unused_instr;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign f7b5     = instr[30];
   assign is_r     = (opcode == OP_R);
   assign is_i     = (opcode == OP_I);
   assign is_ld    = (opcode == OP_LOAD);
   assign is_st    = (opcode == OP_STORE);
   assign is_br    = (opcode == OP_BR);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
   assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // State, wait counter and fault cause registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         cnt_q   <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   // Next state; the counter only survives consecutive unanswered request cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      cause_d = cause_q;
      unique case (state_q)
         S_BOOT:   state_d = S_FETCH;
         S_FETCH, S_MEM: begin
            if (mem_ready) begin
               if (state_q == S_FETCH) state_d = S_DECODE;
               else if (is_st)         state_d = S_FETCH;
               else                    state_d = S_WB;
            end else if (at_limit) begin
               state_d = S_FAULT;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_FAULT;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            if (is_ld || is_st) state_d = S_MEM;
            else if (is_br)     state_d = S_FETCH;
            else                state_d = S_WB;
         end
         S_WB:     state_d = S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_BOOT;
      endcase
   end

   // Datapath controls, decoded from state and the instruction register
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'b00;
      regwrite   = 1'b0;
      wb_sel     = 2'b00;
      alusrc     = 1'b0;
      alua_pc    = 1'b0;
      alucontrol = 3'b000;
      alu_sub    = 1'b0;
      instret    = 1'b0;
      fault      = 1'b0;
      fault_cause = cause_q;

      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         alusrc  = is_i | is_ld | is_st | is_jalr | is_auipc;
         alua_pc = is_auipc;
         if (is_r || is_i || is_br) alucontrol = funct3;
         if (is_r && (funct3 == 3'b000 || funct3 == 3'b101)) alu_sub = f7b5;
         else if (is_i && funct3 == 3'b101)                   alu_sub = f7b5;
         else                                                 alu_sub = is_br;
      end

      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
         end
         S_EXEC: begin
            if (is_br) begin
               pc_we   = 1'b1;
               pc_sel  = br_taken ? 2'b01 : 2'b00;
               instret = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = is_st;
            if (mem_ready && is_st) begin
               pc_we   = 1'b1;
               instret = 1'b1;
            end
         end
         S_WB: begin
            regwrite = 1'b1;
            pc_we    = 1'b1;
            instret  = 1'b1;
            if (is_jal)       pc_sel = 2'b01;
            else if (is_jalr) pc_sel = 2'b10;
            if (is_ld)                 wb_sel = 2'b01;
            else if (is_jal || is_jalr) wb_sel = 2'b10;
            else if (is_lui)           wb_sel = 2'b11;
         end
         S_FAULT:  fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle expected outputs are queued with
// the stimulus and popped when the cycle is sampled.
module tb_multicycle_ctrl_fsm;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_we, pc_we;
      logic [1:0] pc_sel;
      logic       regwrite;
      logic [1:0] wb_sel;
      logic       alusrc, alua_pc;
      logic [2:0] alucontrol;
      logic       alu_sub, instret, fault;
      logic [1:0] fault_cause;
   } outs_t;

   typedef struct packed {
      logic        rstn, ready, br;
      logic [31:0] ins;
   } stim_t;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_SUB   = 32'h40208033;
   localparam logic [31:0] I_SRAI  = 32'h4010D093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h0080006F;
   localparam logic [31:0] I_JALR  = 32'h00008067;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_AUIPC = 32'h00001097;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        br_taken = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, iord, ir_we, pc_we, regwrite, alusrc, alua_pc;
   logic        alu_sub, instret, fault;
   logic [1:0]  pc_sel, wb_sel, fault_cause;
   logic [2:0]  alucontrol;
   outs_t       act;

   int errors = 0;
   int checks = 0;
   stim_t stim_q[$];
   outs_t exp_q[$];

   multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .regwrite(regwrite),
      .wb_sel(wb_sel), .alusrc(alusrc), .alua_pc(alua_pc),
      .alucontrol(alucontrol), .alu_sub(alu_sub), .instret(instret),
      .fault(fault), .fault_cause(fault_cause)
   );

   always #5 clk = ~clk;

   assign act = {mem_req, mem_we, iord, ir_we, pc_we, pc_sel, regwrite, wb_sel,
                 alusrc, alua_pc, alucontrol, alu_sub, instret, fault, fault_cause};

   function automatic stim_t st(input logic rstn, input logic rdy, input logic br,
                                input logic [31:0] ins);
      stim_t s;
      s.rstn = rstn; s.ready = rdy; s.br = br; s.ins = ins;
      return s;
   endfunction

   function automatic outs_t fetch_exp(input logic rdy);
      outs_t e = '0;
      e.mem_req = 1'b1;
      e.ir_we   = rdy;
      return e;
   endfunction

   task automatic push(input stim_t s, input outs_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // FETCH(zero-wait)/DECODE/EXEC/WB for a non-memory, non-branch instruction
   task automatic push_alu(input logic [31:0] ins, input outs_t alu,
                           input logic [1:0] ps, input logic [1:0] ws);
      outs_t w;
      push(st(1, 1, 0, ins), fetch_exp(1));
      push(st(1, 0, 0, ins), '0);
      push(st(1, 0, 0, ins), alu);
      w = alu;
      w.regwrite = 1'b1; w.pc_we = 1'b1; w.instret = 1'b1;
      w.pc_sel = ps; w.wb_sel = ws;
      push(st(1, 0, 0, ins), w);
   endtask

   // Leaves rst_n low at a falling edge; the next queued entry releases it
   task automatic apply_reset();
      rst_n = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      push(st(0, 1, 0, I_ADDI), '0);
      push(st(0, 1, 0, I_ADDI), '0);
      push(st(1, 1, 0, I_ADDI), '0);
      push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL reset cyc%0d: got %h expected %h", i, act, ex);
         end
      end
   endtask

   task automatic test_alu_ops();
      outs_t a;
      apply_reset();
      push(st(1, 0, 0, I_ADDI), '0);
      a = '0; a.alusrc = 1'b1;
      push_alu(I_ADDI, a, 2'b00, 2'b00);
      a = '0; a.alu_sub = 1'b1;
      push_alu(I_SUB, a, 2'b00, 2'b00);
      a = '0; a.alu_sub = 1'b1; a.alusrc = 1'b1; a.alucontrol = 3'b101;
      push_alu(I_SRAI, a, 2'b00, 2'b00);
      a = '0;
      push_alu(I_JAL, a, 2'b01, 2'b10);
      a = '0; a.alusrc = 1'b1;
      push_alu(I_JALR, a, 2'b10, 2'b10);
      a = '0;
      push_alu(I_LUI, a, 2'b00, 2'b11);
      a = '0; a.alusrc = 1'b1; a.alua_pc = 1'b1;
      push_alu(I_AUIPC, a, 2'b00, 2'b00);
      push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL alu_ops cyc%0d instr=%h: got %h expected %h", i, s.ins, act, ex);
         end
      end
   endtask

   task automatic test_load_store();
      outs_t e;
      apply_reset();
      push(st(1, 0, 0, I_LW), '0);
      push(st(1, 1, 0, I_LW), fetch_exp(1));
      push(st(1, 0, 0, I_LW), '0);
      e = '0; e.alusrc = 1'b1;
      push(st(1, 0, 0, I_LW), e);
      e.mem_req = 1'b1; e.iord = 1'b1;
      for (int k = 0; k < 3; k++) push(st(1, 0, 0, I_LW), e);
      push(st(1, 1, 0, I_LW), e);
      e = '0; e.alusrc = 1'b1; e.regwrite = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
      e.wb_sel = 2'b01;
      push(st(1, 0, 0, I_LW), e);
      push(st(1, 1, 0, I_SW), fetch_exp(1));
      push(st(1, 0, 0, I_SW), '0);
      e = '0; e.alusrc = 1'b1;
      push(st(1, 0, 0, I_SW), e);
      e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
      push(st(1, 1, 0, I_SW), e);
      push(st(1, 0, 0, I_SW), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL load_store cyc%0d: got %h expected %h", i, act, ex);
         end
      end
   endtask

   task automatic test_branch();
      outs_t e;
      apply_reset();
      push(st(1, 0, 0, I_BEQ), '0);
      push(st(1, 1, 0, I_BEQ), fetch_exp(1));
      push(st(1, 0, 0, I_BEQ), '0);
      e = '0; e.pc_we = 1'b1; e.pc_sel = 2'b01; e.instret = 1'b1; e.alu_sub = 1'b1;
      push(st(1, 0, 1, I_BEQ), e);
      push(st(1, 1, 0, I_BEQ), fetch_exp(1));
      push(st(1, 0, 1, I_BEQ), '0);
      e.pc_sel = 2'b00;
      push(st(1, 0, 0, I_BEQ), e);
      push(st(1, 0, 0, I_BEQ), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL branch cyc%0d br=%0b: got %h expected %h", i, s.br, act, ex);
         end
      end
   endtask

   task automatic test_illegal();
      outs_t e;
      apply_reset();
      push(st(1, 0, 0, I_ILL), '0);
      push(st(1, 1, 0, I_ILL), fetch_exp(1));
      push(st(1, 1, 0, I_ILL), '0);
      e = '0; e.fault = 1'b1; e.fault_cause = 2'b01;
      for (int k = 0; k < 3; k++) push(st(1, 1, 0, I_ILL), e);
      push(st(0, 1, 0, I_ADDI), '0);
      push(st(1, 0, 0, I_ADDI), '0);
      push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL illegal cyc%0d: got %h expected %h", i, act, ex);
         end
      end
   endtask

   task automatic test_timeout();
      outs_t e;
      apply_reset();
      push(st(1, 0, 0, I_ADDI), '0);
      for (int k = 0; k < 4; k++) push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      e = '0; e.fault = 1'b1; e.fault_cause = 2'b10;
      push(st(1, 0, 0, I_ADDI), e);
      push(st(1, 1, 0, I_ADDI), e);
      push(st(1, 1, 0, I_ADDI), e);
      push(st(0, 0, 0, I_LW), '0);
      push(st(1, 0, 0, I_LW), '0);
      for (int k = 0; k < 3; k++) push(st(1, 0, 0, I_LW), fetch_exp(0));
      push(st(1, 1, 0, I_LW), fetch_exp(1));
      push(st(1, 0, 0, I_LW), '0);
      e = '0; e.alusrc = 1'b1;
      push(st(1, 0, 0, I_LW), e);
      e.mem_req = 1'b1; e.iord = 1'b1;
      for (int k = 0; k < 3; k++) push(st(1, 0, 0, I_LW), e);
      push(st(1, 1, 0, I_LW), e);
      e = '0; e.alusrc = 1'b1; e.regwrite = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
      e.wb_sel = 2'b01;
      push(st(1, 0, 0, I_LW), e);
      push(st(1, 0, 0, I_LW), fetch_exp(0));
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL timeout cyc%0d: got %h expected %h", i, act, ex);
         end
      end
   endtask

   task automatic test_reset_mid_request();
      apply_reset();
      push(st(1, 0, 0, I_ADDI), '0);
      push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      push(st(1, 0, 0, I_ADDI), fetch_exp(0));
      push(st(0, 0, 0, I_ADDI), '0);
      push(st(0, 1, 0, I_ADDI), '0);
      push(st(1, 1, 0, I_ADDI), '0);
      push(st(1, 1, 0, I_ADDI), fetch_exp(1));
      push(st(1, 0, 0, I_ADDI), '0);
      for (int i = 0, n = stim_q.size(); i < n; i++) begin
         stim_t s; outs_t ex;
         if (i != 0) @(negedge clk);
         s = stim_q.pop_front();
         rst_n = s.rstn; mem_ready = s.ready; br_taken = s.br; instr = s.ins;
         #1; ex = exp_q.pop_front(); checks++;
         if (act !== ex) begin
            errors++;
            $display("FAIL reset_mid_req cyc%0d: got %h expected %h", i, act, ex);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load_store();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_request();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
